// File: rtl/pattern_scheduler_pkg.sv
// ============================================================================
// Module   : pattern_scheduler_pkg
// Purpose  : Shared pattern step and game-state encodings for pattern_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pattern_scheduler_pkg;

  localparam logic [3:0] STEP = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pattern_scheduler_hit_judge.sv
// ============================================================================
// Module   : hit_judge
// Purpose  : Judges a press edge against the bottom row; purely combinational.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hit_judge
  import pattern_scheduler_pkg::*;
(
  input  logic [3:0] press,
  input  logic [3:0] row0,
  input  logic       beat,
  output logic [3:0] newRow0,
  output logic [2:0] hitCount,
  output logic       comboClr,
  output logic       comboInc,
  output logic       missInc
);

  logic [3:0] w_hit;
  logic [3:0] w_wrong;

  assign w_hit    = press & row0;
  assign w_wrong  = press & ~row0;
  assign newRow0  = row0 & ~w_hit;
  assign hitCount = {2'b00, w_hit[0]} + {2'b00, w_hit[1]}
                  + {2'b00, w_hit[2]} + {2'b00, w_hit[3]};

  // The miss check sees the row after this cycle's hits have been cleared.
  assign missInc  = beat && (newRow0 != 4'd0);
  assign comboInc = (w_wrong == 4'd0) && (w_hit != 4'd0) && (newRow0 == 4'd0);
  assign comboClr = (w_wrong != 4'd0) || missInc;

endmodule

`default_nettype wire

// File: rtl/pattern_scheduler.sv
// ============================================================================
// Module   : pattern_scheduler
// Purpose  : Falling-pattern lane controller: row buffer, generator, judging, score.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_scheduler
  import pattern_scheduler_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] SEED     = 4'b0001,
  parameter int         MAX_MISS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               beat,
  input  logic [3:0]         keys,
  output logic [4*DEPTH-1:0] rows,
  output logic [9:0]         score,
  output logic [7:0]         combo,
  output logic [3:0]         misses,
  output logic               playing,
  output logic               game_over
);

  state_t             r_state;
  state_t             w_stateNext;
  logic               w_fresh;
  logic [4*DEPTH-1:0] r_rows;
  logic [4*DEPTH-1:0] w_shifted;
  logic [4*DEPTH-1:0] w_judgedRows;
  logic [3:0]         r_gen;
  logic [9:0]         r_score;
  logic [7:0]         r_combo;
  logic [3:0]         r_misses;
  logic [3:0]         r_keysD;
  logic [3:0]         w_press;
  logic [3:0]         w_newRow0;
  logic [2:0]         w_hitCount;
  logic               w_comboClr;
  logic               w_comboInc;
  logic               w_missInc;
  logic [3:0]         w_missesNext;
  logic [10:0]        w_scoreSum;
  logic [8:0]         w_comboSum;

  assign w_press = keys & ~r_keysD;

  hit_judge u_judge (
    .press    (w_press),
    .row0     (r_rows[3:0]),
    .beat     (beat),
    .newRow0  (w_newRow0),
    .hitCount (w_hitCount),
    .comboClr (w_comboClr),
    .comboInc (w_comboInc),
    .missInc  (w_missInc)
  );

  // Row k takes row k+1; the top row takes the generator value.
  for (genvar k = 0; k < DEPTH - 1; k++) begin : g_shift
    assign w_shifted[4*k+3:4*k] = r_rows[4*k+7:4*k+4];
  end
  assign w_shifted[4*DEPTH-1 -: 4] = r_gen;

  always_comb begin
    w_judgedRows      = r_rows;
    w_judgedRows[3:0] = w_newRow0;
  end

  assign w_missesNext = r_misses + {3'b000, w_missInc};
  assign w_scoreSum   = {1'b0, r_score} + {8'd0, w_hitCount};
  assign w_comboSum   = {1'b0, r_combo} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_fresh     = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_stateNext = PLAY;
          w_fresh     = 1'b1;
        end
      end
      PLAY: begin
        if (w_missesNext == 4'(MAX_MISS)) w_stateNext = OVER;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows   <= '0;
      r_gen    <= SEED;
      r_score  <= '0;
      r_combo  <= '0;
      r_misses <= '0;
      r_keysD  <= 4'hF;
    end else begin
      r_keysD <= keys;
      if (w_fresh) begin
        r_rows   <= '0;
        r_gen    <= SEED;
        r_score  <= '0;
        r_combo  <= '0;
        r_misses <= '0;
      end else if (r_state == PLAY) begin
        if (beat) begin
          r_rows <= w_shifted;
          r_gen  <= r_gen + STEP;
        end else begin
          r_rows <= w_judgedRows;
        end
        r_score  <= w_scoreSum[10] ? 10'd1023 : w_scoreSum[9:0];
        r_misses <= w_missesNext;
        if (w_comboClr)      r_combo <= '0;
        else if (w_comboInc) r_combo <= w_comboSum[8] ? 8'd255 : w_comboSum[7:0];
      end
    end
  end

  assign rows      = r_rows;
  assign score     = r_score;
  assign combo     = r_combo;
  assign misses    = r_misses;
  assign playing   = (r_state == PLAY);
  assign game_over = (r_state == OVER);

endmodule

`default_nettype wire

// File: tb/tb_pattern_scheduler.sv
// ============================================================================
// Module   : tb_pattern_scheduler
// Purpose  : Directed plus randomized checks of pattern_scheduler against a lane-level game model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_scheduler;

  localparam int DEPTH    = 4;
  localparam int SEED     = 1;
  localparam int MAX_MISS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        beat = 1'b0;
  logic [3:0]  keys = 4'hF;
  logic [15:0] rows;
  logic [9:0]  score;
  logic [7:0]  combo;
  logic [3:0]  misses;
  logic        playing;
  logic        game_over;

  int passed = 0;
  int total  = 0;

  // Reference model state: 0 = idle, 1 = play, 2 = over
  int mState, mGen, mScore, mCombo, mMisses, mKeysPrev;
  int mRows[DEPTH];

  pattern_scheduler #(.DEPTH(DEPTH), .SEED(4'(SEED)), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .rst(rst), .start(start), .beat(beat), .keys(keys),
    .rows(rows), .score(score), .combo(combo), .misses(misses),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int popcount4(input int v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic void freshGame();
    for (int i = 0; i < DEPTH; i++) mRows[i] = 0;
    mGen = SEED; mScore = 0; mCombo = 0; mMisses = 0;
  endfunction

  function automatic void modelStep(input bit r, input bit s, input bit b, input int k);
    int press, hit, wrong;
    if (r) begin
      freshGame(); mState = 0; mKeysPrev = 15;
      return;
    end
    press = k & ~mKeysPrev & 15;
    mKeysPrev = k;
    if (mState != 1) begin
      if (s) begin freshGame(); mState = 1; end
      return;
    end
    if (press != 0) begin
      hit   = press & mRows[0];
      wrong = press & ~mRows[0] & 15;
      mRows[0] = mRows[0] & ~hit;
      mScore = (mScore + popcount4(hit) > 1023) ? 1023 : mScore + popcount4(hit);
      if (wrong != 0) mCombo = 0;
      else if (mRows[0] == 0 && hit != 0) mCombo = (mCombo == 255) ? 255 : mCombo + 1;
    end
    if (b) begin
      if (mRows[0] != 0) begin mMisses++; mCombo = 0; end
      for (int i = 0; i < DEPTH - 1; i++) mRows[i] = mRows[i+1];
      mRows[DEPTH-1] = mGen;
      mGen = (mGen + 3) % 16;
    end
    if (mMisses == MAX_MISS) mState = 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chkModel(input string tag);
    logic [15:0] er;
    for (int i = 0; i < DEPTH; i++) er[4*i +: 4] = 4'(mRows[i]);
    chk({tag, ".rows"}, 32'(rows), 32'(er));
    chk({tag, ".score"}, 32'(score), 32'(mScore));
    chk({tag, ".combo"}, 32'(combo), 32'(mCombo));
    chk({tag, ".misses"}, 32'(misses), 32'(mMisses));
    chk({tag, ".playing"}, 32'(playing), 32'(mState == 1));
    chk({tag, ".over"}, 32'(game_over), 32'(mState == 2));
  endtask

  // Apply inputs for one cycle, advance the model with them, sample 1 ns after the edge.
  task automatic step(input bit r, input bit s, input bit b, input logic [3:0] k);
    rst = r; start = s; beat = b; keys = k;
    @(posedge clk);
    modelStep(r, s, b, int'(k));
    #1;
  endtask

  initial begin
    logic [15:0] savedRows;
    logic [9:0]  savedScore;
    int          guard;
    logic [3:0]  genSeq [12];
    logic [3:0]  rk;

    genSeq = '{4'h1, 4'h4, 4'h7, 4'hA, 4'hD, 4'h0, 4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h2};
    mKeysPrev = 15; mState = 0; freshGame();

    step(1, 0, 0, 4'hF);
    chkModel("reset");
    chk("reset.allzero", {rows, score, combo, misses, playing, game_over}, 0);
    step(0, 0, 0, 4'hF);
    chk("heldkeys.noscore", 32'(score), 0);
    step(0, 0, 0, 4'h0);
    step(0, 1, 0, 4'h0);
    chk("start.playing", 32'(playing), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0);
    chk("fill.rows", 32'(rows), 32'h0000_A741);
    chk("fill.misses", 32'(misses), 0);
    chkModel("fill");

    step(0, 0, 0, 4'h1);
    chk("hit.row0", 32'(rows[3:0]), 0);
    chk("hit.score", 32'(score), 1);
    chk("hit.combo", 32'(combo), 1);
    step(0, 0, 1, 4'h0);
    chk("beat.row0", 32'(rows[3:0]), 4);
    chk("beat.misses", 32'(misses), 0);
    step(0, 0, 0, 4'h3);
    chk("wrong.row0", 32'(rows[3:0]), 4);
    chk("wrong.score", 32'(score), 1);
    chk("wrong.combo", 32'(combo), 0);
    step(0, 0, 0, 4'h0);
    step(0, 0, 1, 4'h4);
    chk("same.score", 32'(score), 2);
    chk("same.combo", 32'(combo), 1);
    chk("same.misses", 32'(misses), 0);
    chk("same.row0", 32'(rows[3:0]), 7);
    chkModel("same");

    guard = 0;
    while (!game_over && guard < 40) begin
      step(0, 0, 1, 4'h0);
      guard++;
    end
    chk("over.timeout", 32'(guard < 40), 1);
    chk("over.misses", 32'(misses), 8);
    chk("over.flags", {playing, game_over}, 2'b01);
    chkModel("over");
    savedRows = rows; savedScore = score;
    step(0, 0, 1, 4'hF);
    step(0, 0, 1, 4'h0);
    step(0, 0, 0, 4'h6);
    chk("over.holdrows", 32'(rows), 32'(savedRows));
    chk("over.holdscore", 32'(score), 32'(savedScore));
    step(0, 1, 0, 4'h0);
    chk("restart.misses", 32'(misses), 0);
    chk("restart.rows", 32'(rows), 0);
    chk("restart.flags", {playing, game_over}, 2'b10);

    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 4'h0);
      chk($sformatf("gen.%0d", i), 32'(rows[15:12]), 32'(genSeq[i]));
    end
    chkModel("gen");

    step(1, 0, 0, 4'h0);
    chk("midreset.allzero", {rows, score, combo, misses, playing, game_over}, 0);

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      rk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rk = 4'(mRows[0]);
      step($urandom_range(0, 599) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0, rk);
      chkModel("rand");
    end

    step(0, 1, 0, 4'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 4'h0);
    step(0, 0, 0, 4'hF);
    chkModel("preReset");
    step(1, 1, 1, 4'h0);
    chk("lateReset.allzero", {rows, score, combo, misses, playing, game_over}, 0);
    chkModel("lateReset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
